idelay_tap_responder: RTL
=========================

// Module: idelay_tap_responder
// PURPOSE
//  Receiving end of the idelay control bus (hw_addr/hw_data/hw_strobe) produced by the scanner/host multiplexer.
//  Decodes each write to one lane's IDELAYE2 controls, in one of two modes:
//   - load mode: a single LD pulse carrying CNTVALUEIN.
//   - step mode: a sequence of CE/INC steps.
//  Tracks the tap value each lane is believed to hold, and queues one write while busy.
// PARAMETERS
//  LANES      16  number of IDELAYE2 lanes; hw_addr >= LANES is ignored
//  STEP_MODE  0   0 = VAR_LOAD (LD + CNTVALUEIN); 1 = VARIABLE (CE/INC stepping)
//  SETTLE     4   idle cycles after an update completes, before done/next op (1..15)
// PORTS
//  clk           in   1   single clock, IDELAYE2 port C domain
//  rst_n         in   1   asynchronous active-low reset
//  hw_addr       in   4   lane select, valid with hw_strobe
//  hw_data       in   5   target tap value, valid with hw_strobe
//  hw_strobe     in   1   one-cycle write request
//  clr_overflow  in   1   clears overflow sticky
//  tap_addr      in   4   readback lane select
//  tap_val       out  5   believed tap of lane tap_addr, registered
//  idelay_ld     out  16  per-lane LD pulse (load mode)
//  idelay_ce     out  16  per-lane CE pulse (step mode)
//  idelay_inc    out  1   shared INC, valid with any idelay_ce bit
//  cntvaluein    out  5   shared CNTVALUEIN, valid with any idelay_ld bit
//  busy          out  1   operation active or pending
//  done          out  1   one-cycle pulse at end of SETTLE
//  overflow      out  1   sticky: a queued write was overwritten
// BEHAVIOUR
//  Reset: all outputs and the tap table are 0 (IDELAY_VALUE=0 in hardware); FSM goes to IDLE; pending slot is empty.
//  Reset asserted mid-operation aborts it; no partial CE/LD pulse may follow the deassertion of rst_n.
//  Outputs are registered.
//  FSM states: IDLE, LOAD, CMP, STEP, GAP, SETTLE.
//  IDLE:
//   - A valid pending slot is consumed first.
//   - Otherwise a valid hw_strobe is accepted directly.
//   - Next state is LOAD (STEP_MODE=0) or CMP (STEP_MODE=1).
//   - Latched: act_lane and act_target.
//  LOAD: idelay_ld[act_lane]=1 and cntvaluein=act_target for exactly one cycle; tap[act_lane]<=act_target; next state SETTLE.
//  Load-mode latency: a strobe sampled at edge N in IDLE gives LD high during cycle N+1.
//  CMP (step mode):
//   - If tap[act_lane]==act_target, next state is SETTLE (zero-step writes still settle and pulse done).
//   - Otherwise next state is STEP; idelay_inc is registered as (act_target > tap).
//  STEP: idelay_ce[act_lane]=1 for one cycle; tap increments or decrements by 1 (no wrap: 0..31 only); next state GAP.
//  GAP: one idle cycle, then CMP.
//  Step-mode timing: a step every 3 cycles; worst case 0->31 takes 93 cycles plus SETTLE.
//  SETTLE: counts SETTLE cycles; on the last one done=1 and next state IDLE.
//  busy=1 in every state except IDLE, and also whenever pending is valid.
//  Pending slot (depth 1):
//   - A valid strobe not accepted directly from IDLE is stored in pending.
//   - If pending is already full, the new write overwrites it and overflow<=1.
//   - This holds even when pending is consumed in the same cycle: the consumed entry moves to active, the new strobe fills pending, and overflow is not set.
//  Strobes with hw_addr >= LANES are dropped silently (no pending, no overflow).
//  overflow: clr_overflow clears it; if clr_overflow and a new overflow event occur in the same cycle, set wins.
//  Unused mode outputs: idelay_ce=0 and idelay_inc=0 in load mode; idelay_ld=0 in step mode.
//  cntvaluein holds its last value.
//  At most one bit of idelay_ld or idelay_ce is set in any cycle.
//  tap_val <= tap[tap_addr] each cycle (1-cycle latency); tap_addr >= LANES reads 0.
// TESTING
//  1. Reset, STEP_MODE=0; strobe addr=3 data=17:
//     LD[3] high exactly one cycle after the strobe, cntvaluein=17; done SETTLE+1 cycles later; tap_val(3)=17.
//  2. STEP_MODE=1; lane 5 at 0; strobe data=4:
//     four CE[5] pulses spaced 3 cycles apart, inc=1; tap 0->4; then lane 5 back to 1: three pulses, inc=0.
//  3. STEP_MODE=1; write lane 2 = 10 while lane 2 already holds 10:
//     no CE pulse; done after SETTLE.
//  4. Load mode; three strobes (lanes 1,2,3) on consecutive cycles from IDLE:
//     lane 1 loads; lane 3 overwrites pending lane 2; overflow=1; lane 2 never loads; clr_overflow -> 0.
//  5. Strobe addr=15 with LANES=12:
//     no LD/CE, busy stays 0, overflow stays 0.
//  6. Assert rst_n low mid-step (lane 7 heading 0->20):
//     all outputs 0 immediately; after release no CE pulses; tap_val(7)=0.

Source files
------------

// File: rtl/idelay_tap_responder_if.sv
// Idelay control write bus from the scanner/host multiplexer to the tap responder.
// The master drives the lane/tap write; the slave decodes it.
interface idelay_tap_responder_if;
  logic [3:0] hw_addr;
  logic [4:0] hw_data;
  logic       hw_strobe;

  modport master (output hw_addr, output hw_data, output hw_strobe);
  modport slave  (input  hw_addr, input  hw_data, input  hw_strobe);
endinterface

// File: rtl/idelay_tap_responder.sv
// Decodes idelay bus writes into per-lane IDELAYE2 LD or CE/INC pulses, tracks each lane's tap
// value and holds one pending write while an update is in progress.
module idelay_tap_responder #(
  parameter int unsigned LANES     = 16,
  parameter int unsigned STEP_MODE = 0,
  parameter int unsigned SETTLE    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  idelay_tap_responder_if.slave     hw,
  input  logic                      clr_overflow,
  input  logic [3:0]                tap_addr,
  output logic [4:0]                tap_val,
  output logic [LANES-1:0]          idelay_ld,
  output logic [LANES-1:0]          idelay_ce,
  output logic                      idelay_inc,
  output logic [4:0]                cntvaluein,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoad   = 3'd1;
  localparam logic [2:0] StCmp    = 3'd2;
  localparam logic [2:0] StStep   = 3'd3;
  localparam logic [2:0] StGap    = 3'd4;
  localparam logic [2:0] StSettle = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [3:0]       lane_q, lane_d;
  logic [4:0]       tgt_q, tgt_d;
  logic             pend_vld_q, pend_vld_d;
  logic [3:0]       pend_lane_q, pend_lane_d;
  logic [4:0]       pend_data_q, pend_data_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [4:0]       tap_q [LANES];
  logic [4:0]       tap_d [LANES];
  logic [LANES-1:0] ld_q, ld_d, ce_q, ce_d;
  logic             inc_q, inc_d;
  logic [4:0]       cv_q, cv_d;
  logic             busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic [4:0]       tap_val_q, tap_val_d;

  logic       strobe_ok;
  logic       idle_free;
  logic [4:0] cur_tap;

  assign strobe_ok = hw.hw_strobe && (32'(hw.hw_addr) < LANES);
  assign idle_free = (state_q == StIdle) && !pend_vld_q;
  assign cur_tap   = tap_q[lane_q];

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    tgt_d       = tgt_q;
    pend_vld_d  = pend_vld_q;
    pend_lane_d = pend_lane_q;
    pend_data_d = pend_data_q;
    cnt_d       = cnt_q;
    tap_d       = tap_q;
    inc_d       = inc_q;
    cv_d        = cv_q;
    ld_d        = '0;
    ce_d        = '0;
    done_d      = 1'b0;
    ovf_d       = ovf_q & ~clr_overflow;

    case (state_q)
      StIdle: begin
        if (pend_vld_q) begin
          lane_d     = pend_lane_q;
          tgt_d      = pend_data_q;
          pend_vld_d = 1'b0;
          state_d    = (STEP_MODE != 0) ? StCmp : StLoad;
        end else if (strobe_ok) begin
          lane_d  = hw.hw_addr;
          tgt_d   = hw.hw_data;
          state_d = (STEP_MODE != 0) ? StCmp : StLoad;
        end
      end
      StLoad: begin
        tap_d[lane_q] = tgt_q;
        cnt_d         = '0;
        state_d       = StSettle;
      end
      StCmp: begin
        if (cur_tap == tgt_q) begin
          cnt_d   = '0;
          state_d = StSettle;
        end else begin
          inc_d   = (tgt_q > cur_tap);
          state_d = StStep;
        end
      end
      StStep: begin
        // Saturate rather than wrap; the compare already keeps us inside 0..31.
        if (inc_q && (cur_tap != 5'd31)) begin
          tap_d[lane_q] = cur_tap + 5'd1;
        end else if (!inc_q && (cur_tap != 5'd0)) begin
          tap_d[lane_q] = cur_tap - 5'd1;
        end
        state_d = StGap;
      end
      StGap: state_d = StCmp;
      StSettle: begin
        if (cnt_q == 4'(SETTLE - 1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A strobe not taken straight from IDLE lands in the pending slot; a slot being consumed
    // this cycle is not an overwrite.
    if (strobe_ok && !idle_free) begin
      if (pend_vld_q && (state_q != StIdle)) begin
        ovf_d = 1'b1;
      end
      pend_vld_d  = 1'b1;
      pend_lane_d = hw.hw_addr;
      pend_data_d = hw.hw_data;
    end

    if (state_d == StLoad) begin
      ld_d[lane_d] = 1'b1;
      cv_d         = tgt_d;
    end
    if (state_d == StStep) begin
      ce_d[lane_d] = 1'b1;
    end

    busy_d    = (state_d != StIdle) || pend_vld_d;
    tap_val_d = (32'(tap_addr) < LANES) ? tap_q[tap_addr] : 5'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lane_q      <= '0;
      tgt_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_lane_q <= '0;
      pend_data_q <= '0;
      cnt_q       <= '0;
      tap_q       <= '{default: '0};
      ld_q        <= '0;
      ce_q        <= '0;
      inc_q       <= 1'b0;
      cv_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      tap_val_q   <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      tgt_q       <= tgt_d;
      pend_vld_q  <= pend_vld_d;
      pend_lane_q <= pend_lane_d;
      pend_data_q <= pend_data_d;
      cnt_q       <= cnt_d;
      tap_q       <= tap_d;
      ld_q        <= ld_d;
      ce_q        <= ce_d;
      inc_q       <= inc_d;
      cv_q        <= cv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      tap_val_q   <= tap_val_d;
    end
  end

  assign idelay_ld  = ld_q;
  assign idelay_ce  = ce_q;
  assign idelay_inc = inc_q;
  assign cntvaluein = cv_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign tap_val    = tap_val_q;

endmodule
